// File: rtl/alu_wb_pkg.sv
// Shared constants for the ALU writeback stage: flag layout and default datapath widths.
// Imported by the ALU-side interface, the FIFO wrapper and the top level.
package alu_wb_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_OP_W   = 6;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle between the ALU, the writeback stage and the register-file writeback.
// The slave modport is the stage's view; master is the surrounding environment's view.
interface alu_writeback_stage_if
  import alu_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OP_W   = DEF_OP_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              in_over;

  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_result;
  logic [FLAG_W-1:0] out_flags;

  modport slave (
    input  in_valid, in_op, in_result, in_carry, in_over, out_ready,
    output in_ready, out_valid, out_op, out_result, out_flags
  );

  modport master (
    output in_valid, in_op, in_result, in_carry, in_over, out_ready,
    input  in_ready, out_valid, out_op, out_result, out_flags
  );

endinterface

// File: rtl/alu_wb_fifo.sv
// Generic synchronous FIFO with wrap-around pointers and an occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module alu_wb_fifo #(
  parameter int unsigned  WIDTH = 42,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_writeback_stage.sv
// Buffers ALU results with derived N/Z/C/V flags toward register-file writeback,
// and keeps a sticky flag register plus a saturating signed-overflow counter.
module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int unsigned  DATA_W = DEF_DATA_W,
  parameter int unsigned  OP_W   = DEF_OP_W,
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  CNT_W  = 8,
  localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  alu_writeback_stage_if.slave bus,
  output logic [CntW-1:0]   count,
  input  logic              sticky_clr,
  output logic [FLAG_W-1:0] sticky_flags,
  output logic [CNT_W-1:0]  over_cnt
);

  localparam int unsigned EntryW = OP_W + DATA_W + FLAG_W;

  logic              push, pop, full, empty;
  logic [FLAG_W-1:0] in_flags;
  logic [EntryW-1:0] head;
  logic [FLAG_W-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  over_cnt_q, over_cnt_d;

  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_N] = bus.in_result[DATA_W-1];
    in_flags[FLAG_Z] = (bus.in_result == '0);
    in_flags[FLAG_C] = bus.in_carry;
    in_flags[FLAG_V] = bus.in_over;
  end

  // Readiness comes from occupancy alone, so a full FIFO refuses even with a same-cycle pop.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full;
  assign pop           = !empty && bus.out_ready;

  alu_wb_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_op, bus.in_result, in_flags}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    bus.out_op     = '0;
    bus.out_result = '0;
    bus.out_flags  = '0;
    if (!empty) begin
      bus.out_op     = head[EntryW-1 -: OP_W];
      bus.out_result = head[FLAG_W +: DATA_W];
      bus.out_flags  = head[FLAG_W-1:0];
    end
  end

  always_comb begin
    sticky_d   = (sticky_clr ? '0 : sticky_q) | (push ? in_flags : '0);
    over_cnt_d = over_cnt_q;
    if (push && in_flags[FLAG_V] && (over_cnt_q != {CNT_W{1'b1}})) begin
      over_cnt_d = over_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q   <= '0;
      over_cnt_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      over_cnt_q <= over_cnt_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign over_cnt     = over_cnt_q;

endmodule
